dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port synchronous data RAM between the processor core and
// an auxiliary burst engine. The core normally has priority. The burst engine
// is force-granted once it has been denied STARVE_MAX cycles in a row. RAM
// select/address/data are driven combinationally from the current-cycle grant.
// Read data comes back one cycle later with a one-cycle valid strobe.

`ifndef DMEMADDRW
`define DMEMADDRW 10
`endif

module dmem_arbiter #(
    parameter int ADDR_W     = `DMEMADDRW,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    // core port
    input  logic              core_en_b,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_indir,
    input  logic [ADDR_W-1:0] core_ptr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    // aux burst port
    input  logic              aux_start,
    input  logic              aux_rw,
    input  logic [ADDR_W-1:0] aux_base,
    input  logic [LEN_W-1:0]  aux_len,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_wack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              aux_busy,
    output logic              aux_done,
    // RAM port
    output logic              ram_cs_b,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Starve counter only needs to reach STARVE_MAX; keep at least one bit.
    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_PREEMPT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              core_rv_q, core_rv_d;
    logic              aux_rv_q, aux_rv_d;
    logic [DATA_W-1:0] core_rd_q;
    logic [DATA_W-1:0] aux_rd_q;

    logic              core_req;
    logic              aux_pend;
    logic              force_aux;
    logic              core_gnt;
    logic              aux_gnt;
    logic              start_ok;

    // Grant decision for this cycle; nothing is granted while reset is held.
    always_comb begin
        core_req  = rst_b & ~core_en_b;
        aux_pend  = (state_q != ST_IDLE);
        force_aux = aux_pend && (starve_q == STARVE_LIM);
        core_gnt  = core_req && !force_aux;
        aux_gnt   = rst_b && aux_pend && !core_gnt;
        // A new burst is only accepted once the previous one has fully
        // retired, including its aux_done cycle.
        start_ok  = aux_start && !busy_q && (state_q == ST_IDLE);
    end

    // RAM drive follows the grant directly; idle drive is a deselected read at 0.
    always_comb begin
        ram_cs_b  = 1'b1;
        ram_rw    = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (core_gnt) begin
            ram_cs_b  = 1'b0;
            ram_rw    = core_rw;
            ram_addr  = core_indir ? core_ptr : core_addr;
            ram_wdata = core_wdata;
        end else if (aux_gnt) begin
            ram_cs_b  = 1'b0;
            ram_rw    = dir_q;
            ram_addr  = addr_q;
            ram_wdata = aux_wdata;
        end
    end

    // Burst sequencing, starvation tracking and status flag next-state logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        starve_d  = starve_q;
        done_d    = 1'b0;
        core_rv_d = core_gnt && core_rw;
        aux_rv_d  = aux_gnt && dir_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    if (aux_len == '0) begin
                        // Empty burst: report completion without touching RAM.
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        addr_d  = aux_base;
                        rem_d   = aux_len;
                        dir_d   = aux_rw;
                    end
                end
            end
            ST_BURST, ST_PREEMPT: begin
                if (aux_gnt) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    rem_d    = rem_q - LEN_W'(1);
                    starve_d = '0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else if (core_gnt) begin
                    starve_d = starve_q + SW'(1);
                    state_d  = ST_PREEMPT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // Control state and registered status flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            starve_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            core_rv_q <= 1'b0;
            aux_rv_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            core_rv_q <= core_rv_d;
            aux_rv_q  <= aux_rv_d;
        end
    end

    // Hold the last returned read word so rdata stays stable between strobes.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            core_rd_q <= '0;
            aux_rd_q  <= '0;
        end else begin
            if (core_rv_q) begin
                core_rd_q <= ram_rdata;
            end
            if (aux_rv_q) begin
                aux_rd_q <= ram_rdata;
            end
        end
    end

    // The RAM word is only present during the strobe cycle, so it is passed
    // straight through then and replayed from the hold register afterwards.
    assign core_rdata  = core_rv_q ? ram_rdata : core_rd_q;
    assign aux_rdata   = aux_rv_q  ? ram_rdata : aux_rd_q;
    assign core_rvalid = core_rv_q;
    assign aux_rvalid  = aux_rv_q;

    // Stall and write-acknowledge must track the live grant, so they are
    // decoded directly from it rather than registered.
    assign core_stall  = core_req & aux_gnt;
    assign aux_wack    = aux_gnt & ~dir_q;
    assign aux_busy    = busy_q;
    assign aux_done    = done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of the arbitration rules and RAM contents.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SM = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_b;
    logic          core_en_b, core_rw, core_indir;
    logic [AW-1:0] core_addr, core_ptr;
    logic [DW-1:0] core_wdata;
    logic          core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          aux_start, aux_rw;
    logic [AW-1:0] aux_base;
    logic [LW-1:0] aux_len;
    logic [DW-1:0] aux_wdata;
    logic          aux_wack, aux_rvalid, aux_busy, aux_done;
    logic [DW-1:0] aux_rdata;
    logic          ram_cs_b, ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_MAX(SM)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .core_en_b(core_en_b), .core_rw(core_rw), .core_addr(core_addr),
        .core_indir(core_indir), .core_ptr(core_ptr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .aux_start(aux_start), .aux_rw(aux_rw), .aux_base(aux_base), .aux_len(aux_len),
        .aux_wdata(aux_wdata), .aux_wack(aux_wack), .aux_rdata(aux_rdata),
        .aux_rvalid(aux_rvalid), .aux_busy(aux_busy), .aux_done(aux_done),
        .ram_cs_b(ram_cs_b), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = {{(DW-AW){1'b0}}, a};
        return (w * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // Synchronous RAM: read data appears the cycle after the select; garbage otherwise.
    logic [DW-1:0] ram_mem [0:DEPTH-1];
    bit            ram_wr  [0:DEPTH-1];
    always @(posedge clk) begin
        if (!ram_cs_b && !ram_rw) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_wr[ram_addr]  <= 1'b1;
        end
        if (!ram_cs_b && ram_rw)
            ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_pat(ram_addr);
        else
            ram_rdata <= $urandom;
    end

    // ---------------- behavioural reference model ----------------
    logic [DW-1:0] shadow [0:DEPTH-1];
    bit            sh_wr  [0:DEPTH-1];

    bit            m_active, m_dir, m_busy, m_done, m_crv, m_arv;
    int            m_left, m_denied;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_crd, m_ard;

    bit            e_core_gnt, e_aux_gnt, e_cs_b, e_rw, e_stall, e_wack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return sh_wr[a] ? shadow[a] : init_pat(a);
    endfunction

    task automatic model_reset();
        m_active = 0; m_dir = 0; m_busy = 0; m_done = 0; m_crv = 0; m_arv = 0;
        m_left = 0; m_denied = 0; m_addr = '0; m_crd = '0; m_ard = '0;
    endtask

    // Who owns the RAM this cycle: core first, unless the burst has waited too long.
    task automatic model_eval();
        bit creq, starving;
        creq       = rst_b && !core_en_b;
        starving   = m_active && (m_denied == SM);
        e_core_gnt = creq && !starving;
        e_aux_gnt  = rst_b && m_active && !e_core_gnt;
        e_cs_b     = !(e_core_gnt || e_aux_gnt);
        e_rw       = 1'b1;
        e_addr     = '0;
        e_wdata    = '0;
        if (e_core_gnt) begin
            e_rw    = core_rw;
            e_addr  = core_indir ? core_ptr : core_addr;
            e_wdata = core_wdata;
        end else if (e_aux_gnt) begin
            e_rw    = m_dir;
            e_addr  = m_addr;
            e_wdata = aux_wdata;
        end
        e_stall = creq && e_aux_gnt;
        e_wack  = e_aux_gnt && !m_dir;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    // Advance one clock: apply this cycle's effects to the model, return at negedge.
    task automatic tick();
        bit n_crv, n_arv, n_done;
        model_eval();
        @(posedge clk);
        if (rst_b) begin
            n_crv = 0; n_arv = 0; n_done = 0;
            if (e_core_gnt && core_rw) begin n_crv = 1; m_crd = shadow_rd(e_addr); end
            if (e_aux_gnt && m_dir)    begin n_arv = 1; m_ard = shadow_rd(e_addr); end
            if (!e_cs_b && !e_rw) begin shadow[e_addr] = e_wdata; sh_wr[e_addr] = 1; end
            if (e_aux_gnt) begin
                m_addr   = AW'((int'(m_addr) + 1) % DEPTH);
                m_left   = m_left - 1;
                m_denied = 0;
                if (m_left == 0) begin m_active = 0; n_done = 1; end
            end else if (e_core_gnt && m_active) begin
                m_denied = m_denied + 1;
            end
            if (aux_start && !m_busy) begin
                if (aux_len == '0) n_done = 1;
                else begin
                    m_active = 1; m_left = int'(aux_len); m_addr = aux_base; m_dir = aux_rw;
                end
            end
            m_crv = n_crv; m_arv = n_arv; m_done = n_done;
            m_busy = m_active || n_done;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        core_en_b = 1; core_rw = 1; core_indir = 0; core_addr = '0; core_ptr = '0;
        core_wdata = '0; aux_start = 0; aux_rw = 1; aux_base = '0; aux_len = '0;
        aux_wdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_b = 0;
        core_en_b = 0; core_rw = 0; core_addr = 10'h155;
        model_reset();
        #2;
        checks++; if (ram_cs_b !== 1'b1)  begin failures++; $display("FAIL rst_cs got %b want 1", ram_cs_b); end
        checks++; if (ram_rw !== 1'b1)    begin failures++; $display("FAIL rst_rw got %b want 1", ram_rw); end
        checks++; if (ram_addr !== '0)    begin failures++; $display("FAIL rst_addr got %h want 0", ram_addr); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got %b want 0", core_stall); end
        checks++; if ({aux_busy, aux_done, aux_wack, core_rvalid, aux_rvalid} !== 5'b0)
            begin failures++; $display("FAIL rst_flags got %b want 00000", {aux_busy, aux_done, aux_wack, core_rvalid, aux_rvalid}); end
        checks++; if (core_rdata !== '0)  begin failures++; $display("FAIL rst_crdata got %h want 0", core_rdata); end
        checks++; if (aux_rdata !== '0)   begin failures++; $display("FAIL rst_ardata got %h want 0", aux_rdata); end
        @(negedge clk);
        idle_inputs();
        rst_b = 1;
        tick();
    endtask

    task automatic test_core_read_indir();
        logic [DW-1:0] exp_d;
        exp_d = shadow_rd(10'h012);
        core_en_b = 0; core_rw = 1; core_indir = 1; core_ptr = 10'h012; core_addr = 10'h155;
        settle();
        checks++; if (ram_addr !== 10'h012) begin failures++; $display("FAIL indir_addr got %h want 012", ram_addr); end
        checks++; if (ram_cs_b !== 1'b0 || ram_rw !== 1'b1)
            begin failures++; $display("FAIL indir_sel got cs=%b rw=%b want cs=0 rw=1", ram_cs_b, ram_rw); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL indir_stall got %b want 0", core_stall); end
        tick();
        idle_inputs();
        settle();
        checks++; if (core_rvalid !== 1'b1) begin failures++; $display("FAIL indir_rvalid got %b want 1", core_rvalid); end
        checks++; if (core_rdata !== exp_d) begin failures++; $display("FAIL indir_rdata got %h want %h", core_rdata, exp_d); end
        tick();
        settle();
        checks++; if (core_rvalid !== 1'b0) begin failures++; $display("FAIL indir_rvalid_pulse got %b want 0", core_rvalid); end
        checks++; if (core_rdata !== exp_d) begin failures++; $display("FAIL indir_rdata_hold got %h want %h", core_rdata, exp_d); end
        tick();
    endtask

    task automatic test_wrap_burst();
        logic [AW-1:0] exp_a [4];
        int wacks;
        exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
        wacks = 0;
        aux_start = 1; aux_rw = 0; aux_base = 10'h3FE; aux_len = 8'd4;
        settle();
        checks++; if (ram_cs_b !== 1'b1) begin failures++; $display("FAIL wrap_start_cs got %b want 1", ram_cs_b); end
        tick();
        aux_start = 0;
        for (int k = 0; k < 4; k++) begin
            aux_wdata = $urandom;
            // A start pulse mid-burst must not disturb the running burst.
            if (k == 1) begin aux_start = 1; aux_base = 10'h100; aux_len = 8'd3; aux_rw = 1; end
            else aux_start = 0;
            settle();
            checks++; if (ram_cs_b !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== exp_a[k])
                begin failures++; $display("FAIL wrap_word%0d got cs=%b rw=%b addr=%h want cs=0 rw=0 addr=%h", k, ram_cs_b, ram_rw, ram_addr, exp_a[k]); end
            checks++; if (ram_wdata !== aux_wdata)
                begin failures++; $display("FAIL wrap_wdata%0d got %h want %h", k, ram_wdata, aux_wdata); end
            if (aux_wack === 1'b1) wacks++;
            tick();
        end
        aux_start = 1;
        settle();
        checks++; if (wacks != 4) begin failures++; $display("FAIL wrap_wack_count got %0d want 4", wacks); end
        checks++; if (aux_done !== 1'b1 || aux_busy !== 1'b1)
            begin failures++; $display("FAIL wrap_done got done=%b busy=%b want 1 1", aux_done, aux_busy); end
        checks++; if (ram_cs_b !== 1'b1) begin failures++; $display("FAIL wrap_done_cs got %b want 1", ram_cs_b); end
        tick();
        aux_start = 0;
        settle();
        checks++; if (aux_done !== 1'b0 || aux_busy !== 1'b0 || ram_cs_b !== 1'b1)
            begin failures++; $display("FAIL wrap_after got done=%b busy=%b cs=%b want 0 0 1", aux_done, aux_busy, ram_cs_b); end
        tick();
    endtask

    task automatic test_len_zero();
        aux_start = 1; aux_len = '0; aux_base = 10'h0AA; aux_rw = 1;
        settle();
        checks++; if (ram_cs_b !== 1'b1) begin failures++; $display("FAIL len0_cs0 got %b want 1", ram_cs_b); end
        tick();
        aux_start = 0;
        settle();
        checks++; if (aux_done !== 1'b1 || ram_cs_b !== 1'b1)
            begin failures++; $display("FAIL len0_done got done=%b cs=%b want 1 1", aux_done, ram_cs_b); end
        tick();
        settle();
        checks++; if (aux_done !== 1'b0 || aux_busy !== 1'b0 || ram_cs_b !== 1'b1)
            begin failures++; $display("FAIL len0_after got done=%b busy=%b cs=%b want 0 0 1", aux_done, aux_busy, ram_cs_b); end
        tick();
    endtask

    task automatic test_starve();
        logic [AW-1:0] base;
        int grants;
        bit want_aux;
        base = AW'($urandom);
        grants = 0;
        core_en_b = 0; core_rw = 0; core_indir = 0;
        core_addr = AW'($urandom); core_wdata = $urandom;
        aux_start = 1; aux_rw = 1; aux_base = base; aux_len = 8'd8;
        settle();
        checks++; if (core_stall !== 1'b0 || ram_addr !== core_addr)
            begin failures++; $display("FAIL starve_first got stall=%b addr=%h want 0 %h", core_stall, ram_addr, core_addr); end
        tick();
        aux_start = 0;
        for (int k = 1; k <= 41; k++) begin
            core_addr = AW'($urandom); core_wdata = $urandom;
            settle();
            want_aux = ((k % 5) == 0) && (grants < 8);
            checks++; if (core_stall !== want_aux)
                begin failures++; $display("FAIL starve_stall cycle %0d got %b want %b", k, core_stall, want_aux); end
            if (want_aux) begin
                checks++; if (ram_addr !== AW'(int'(base) + grants) || ram_rw !== 1'b1)
                    begin failures++; $display("FAIL starve_aux_addr cycle %0d got %h want %h", k, ram_addr, AW'(int'(base) + grants)); end
                grants++;
            end
            checks++; if (aux_rvalid !== m_arv)
                begin failures++; $display("FAIL starve_rvalid cycle %0d got %b want %b", k, aux_rvalid, m_arv); end
            if (m_arv) begin
                checks++; if (aux_rdata !== m_ard)
                    begin failures++; $display("FAIL starve_rdata cycle %0d got %h want %h", k, aux_rdata, m_ard); end
            end
            checks++; if (aux_done !== (k == 41))
                begin failures++; $display("FAIL starve_done cycle %0d got %b want %b", k, aux_done, (k == 41)); end
            tick();
        end
        idle_inputs();
        settle();
        checks++; if (aux_busy !== 1'b0) begin failures++; $display("FAIL starve_busy_end got %b want 0", aux_busy); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [AW-1:0] base;
        base = 10'h2C0;
        aux_start = 1; aux_rw = 1; aux_base = base; aux_len = 8'd6;
        tick();
        aux_start = 0;
        tick();
        tick();
        settle();
        checks++; if (ram_cs_b !== 1'b0 || ram_addr !== 10'h2C2 || aux_rvalid !== 1'b1)
            begin failures++; $display("FAIL midrst_pre got cs=%b addr=%h rv=%b want 0 2c2 1", ram_cs_b, ram_addr, aux_rvalid); end
        core_en_b = 0; core_rw = 1;
        rst_b = 0;
        #1;
        model_reset();
        checks++; if (ram_cs_b !== 1'b1 || ram_rw !== 1'b1 || ram_addr !== '0)
            begin failures++; $display("FAIL midrst_ram got cs=%b rw=%b addr=%h want 1 1 0", ram_cs_b, ram_rw, ram_addr); end
        checks++; if ({aux_busy, aux_done, aux_wack, core_rvalid, aux_rvalid, core_stall} !== 6'b0)
            begin failures++; $display("FAIL midrst_flags got %b want 000000", {aux_busy, aux_done, aux_wack, core_rvalid, aux_rvalid, core_stall}); end
        checks++; if (aux_rdata !== '0 || core_rdata !== '0)
            begin failures++; $display("FAIL midrst_rdata got %h %h want 0 0", aux_rdata, core_rdata); end
        tick();
        tick();
        idle_inputs();
        rst_b = 1;
        for (int k = 0; k < 8; k++) begin
            settle();
            checks++; if (aux_rvalid !== 1'b0 || aux_done !== 1'b0 || ram_cs_b !== 1'b1)
                begin failures++; $display("FAIL midrst_quiet cycle %0d got rv=%b done=%b cs=%b want 0 0 1", k, aux_rvalid, aux_done, ram_cs_b); end
            tick();
        end
        aux_start = 1; aux_rw = 1; aux_base = 10'h077; aux_len = 8'd1;
        tick();
        aux_start = 0;
        settle();
        checks++; if (ram_cs_b !== 1'b0 || ram_addr !== 10'h077)
            begin failures++; $display("FAIL midrst_restart got cs=%b addr=%h want 0 077", ram_cs_b, ram_addr); end
        tick();
        settle();
        checks++; if (aux_rvalid !== 1'b1 || aux_done !== 1'b1 || aux_rdata !== shadow_rd(10'h077))
            begin failures++; $display("FAIL midrst_restart_rd got rv=%b done=%b d=%h want 1 1 %h", aux_rvalid, aux_done, aux_rdata, shadow_rd(10'h077)); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] cd;
        cd = $urandom;
        aux_start = 1; aux_rw = 0; aux_base = 10'h2A0; aux_len = 8'd2;
        core_en_b = 0; core_rw = 0; core_indir = 0; core_addr = 10'h0C0; core_wdata = cd;
        aux_wdata = $urandom;
        settle();
        checks++; if (ram_cs_b !== 1'b0 || ram_rw !== 1'b0 || ram_addr !== 10'h0C0 || ram_wdata !== cd)
            begin failures++; $display("FAIL b2b_core got cs=%b rw=%b addr=%h d=%h want 0 0 0c0 %h", ram_cs_b, ram_rw, ram_addr, ram_wdata, cd); end
        checks++; if (aux_wack !== 1'b0 || core_stall !== 1'b0)
            begin failures++; $display("FAIL b2b_core_flags got wack=%b stall=%b want 0 0", aux_wack, core_stall); end
        tick();
        idle_inputs();
        aux_rw = 0;
        for (int k = 0; k < 2; k++) begin
            aux_wdata = $urandom;
            settle();
            checks++; if (ram_addr !== AW'(10'h2A0 + k) || aux_wack !== 1'b1 || ram_wdata !== aux_wdata)
                begin failures++; $display("FAIL b2b_aux%0d got addr=%h wack=%b want %h 1", k, ram_addr, aux_wack, AW'(10'h2A0 + k)); end
            tick();
        end
        settle();
        checks++; if (aux_done !== 1'b1) begin failures++; $display("FAIL b2b_done got %b want 1", aux_done); end
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            core_en_b  = ($urandom_range(0, 2) == 0);
            core_rw    = $urandom_range(0, 1);
            core_indir = $urandom_range(0, 1);
            core_addr  = AW'($urandom);
            core_ptr   = AW'($urandom);
            core_wdata = $urandom;
            aux_start  = ($urandom_range(0, 5) == 0);
            aux_rw     = $urandom_range(0, 1);
            aux_base   = AW'($urandom);
            aux_len    = LW'($urandom_range(0, 6));
            aux_wdata  = $urandom;
            settle();
            checks++; if (ram_cs_b !== e_cs_b || ram_rw !== e_rw || ram_addr !== e_addr)
                begin failures++; $display("FAIL rnd_ram cycle %0d got cs=%b rw=%b addr=%h want %b %b %h", c, ram_cs_b, ram_rw, ram_addr, e_cs_b, e_rw, e_addr); end
            if (!e_cs_b && !e_rw) begin
                checks++; if (ram_wdata !== e_wdata)
                    begin failures++; $display("FAIL rnd_wdata cycle %0d got %h want %h", c, ram_wdata, e_wdata); end
            end
            checks++; if (core_stall !== e_stall || aux_wack !== e_wack)
                begin failures++; $display("FAIL rnd_stall_wack cycle %0d got %b%b want %b%b", c, core_stall, aux_wack, e_stall, e_wack); end
            checks++; if (core_rvalid !== m_crv || core_rdata !== m_crd)
                begin failures++; $display("FAIL rnd_core_rd cycle %0d got %b %h want %b %h", c, core_rvalid, core_rdata, m_crv, m_crd); end
            checks++; if (aux_rvalid !== m_arv || aux_rdata !== m_ard)
                begin failures++; $display("FAIL rnd_aux_rd cycle %0d got %b %h want %b %h", c, aux_rvalid, aux_rdata, m_arv, m_ard); end
            checks++; if (aux_busy !== m_busy || aux_done !== m_done)
                begin failures++; $display("FAIL rnd_status cycle %0d got busy=%b done=%b want %b %b", c, aux_busy, aux_done, m_busy, m_done); end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 100 && m_busy; k++) tick();
        checks++; if (m_busy || aux_busy !== 1'b0)
            begin failures++; $display("FAIL rnd_drain busy=%b model=%b after bound", aux_busy, m_busy); end
    endtask

    initial begin
        test_reset();
        test_core_read_indir();
        test_wrap_burst();
        test_len_zero();
        test_starve();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
